// File: rtl/present_slot_scheduler.sv
// present_slot_scheduler
//   Allocates falling presents into a pool of 4 on-screen slots. A drop request
//   takes the lowest free slot and loads a pseudo-random type and X position
//   from a free-running 16-bit Galois LFSR. A slot is freed when its present is
//   collected or when it has lived LIFETIME_SEC seconds.
//
// Ports:
//   clk          system clock
//   resetN       synchronous active-low reset
//   secClk       one-cycle pulse, once per second (ages live slots)
//   playActive   high while the game is in play mode; low clears the pool
//   dropReq      one-cycle drop request
//   collectValid one-cycle pulse: player touched the present in collectSlot
//   collectSlot  slot index of the touched present
//   slotValid    bit i = slot i holds a live present
//   slotType     2 bits per slot (00 life, 01 super rope, 10 super speed, 11 immortal)
//   slotX        11 bits per slot, spawn X position
//   dropGrant    one-cycle pulse: a drop was allocated into dropSlot
//   dropSlot     granted slot index (holds between grants)
//   dropOverflow one-cycle pulse: drop requested while every slot was busy
//   collectPulse one-cycle pulse: collection accepted
//   collectType  type of the collected present (holds between collections)
module present_slot_scheduler #(
  parameter int unsigned LIFETIME_SEC = 6,
  parameter int unsigned X_MIN        = 32,
  parameter int unsigned X_SPAN       = 576,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        secClk,
  input  logic        playActive,
  input  logic        dropReq,
  input  logic        collectValid,
  input  logic [1:0]  collectSlot,
  output logic [3:0]  slotValid,
  output logic [7:0]  slotType,
  output logic [43:0] slotX,
  output logic        dropGrant,
  output logic [1:0]  dropSlot,
  output logic        dropOverflow,
  output logic        collectPulse,
  output logic [1:0]  collectType
);

  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [2:0]  AGE_LAST  = 3'(LIFETIME_SEC - 1);
  localparam logic [10:0] X_MIN_W   = 11'(X_MIN);
  localparam logic [10:0] X_SPAN_W  = 11'(X_SPAN);

  logic [15:0] lfsr_r;
  logic [11:0] age_r;

  logic        free_any_s;
  logic [1:0]  free_idx_s;
  logic [10:0] raw_s;
  logic [10:0] off_s;
  logic [10:0] spawn_x_s;
  logic [1:0]  spawn_type_s;
  logic        drop_ok_s;
  logic        overflow_s;
  logic        collect_ok_s;
  logic [3:0]  valid_n_s;
  logic [7:0]  type_n_s;
  logic [43:0] x_n_s;
  logic [11:0] age_n_s;

  // Lowest free slot, judged on the mask as it stood before this edge.
  always_comb begin
    free_any_s = 1'b1;
    free_idx_s = 2'd0;
    casez (slotValid)
      4'b???0: free_idx_s = 2'd0;
      4'b??01: free_idx_s = 2'd1;
      4'b?011: free_idx_s = 2'd2;
      4'b0111: free_idx_s = 2'd3;
      default: free_any_s = 1'b0;
    endcase
  end

  // Spawn values taken from the current LFSR; the offset folds the 10-bit
  // raw value into [0, X_SPAN-1] with a single conditional subtract.
  always_comb begin
    spawn_type_s = lfsr_r[15:14];
    raw_s        = {1'b0, lfsr_r[9:0]};
    if (raw_s >= X_SPAN_W) begin
      off_s = raw_s - X_SPAN_W;
    end else begin
      off_s = raw_s;
    end
    spawn_x_s = X_MIN_W + off_s;
  end

  // Event qualification: nothing is accepted outside play mode.
  always_comb begin
    drop_ok_s    = playActive & dropReq & free_any_s;
    overflow_s   = playActive & dropReq & ~free_any_s;
    collect_ok_s = playActive & collectValid & slotValid[collectSlot];
  end

  // Per-slot next state. Collect outranks expiry; a slot being allocated
  // starts at age 0 even when secClk fires in the same cycle.
  always_comb begin
    valid_n_s = slotValid;
    type_n_s  = slotType;
    x_n_s     = slotX;
    age_n_s   = age_r;
    for (int i = 0; i < 4; i++) begin
      if (!playActive) begin
        valid_n_s[i]          = 1'b0;
        age_n_s[3*i +: 3]     = 3'd0;
        type_n_s[2*i +: 2]    = 2'd0;
        x_n_s[11*i +: 11]     = 11'd0;
      end else if (collect_ok_s && (collectSlot == 2'(i))) begin
        valid_n_s[i]          = 1'b0;
        age_n_s[3*i +: 3]     = 3'd0;
      end else if (drop_ok_s && (free_idx_s == 2'(i))) begin
        valid_n_s[i]          = 1'b1;
        age_n_s[3*i +: 3]     = 3'd0;
        type_n_s[2*i +: 2]    = spawn_type_s;
        x_n_s[11*i +: 11]     = spawn_x_s;
      end else if (secClk && slotValid[i]) begin
        if (age_r[3*i +: 3] == AGE_LAST) begin
          valid_n_s[i]        = 1'b0;
          age_n_s[3*i +: 3]   = 3'd0;
        end else begin
          age_n_s[3*i +: 3]   = age_r[3*i +: 3] + 3'd1;
        end
      end else begin
        age_n_s[3*i +: 3]     = age_r[3*i +: 3];
      end
    end
  end

  // State and registered outputs; the LFSR free-runs outside reset.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      lfsr_r       <= LFSR_SEED;
      slotValid    <= 4'd0;
      slotType     <= 8'd0;
      slotX        <= 44'd0;
      age_r        <= 12'd0;
      dropGrant    <= 1'b0;
      dropSlot     <= 2'd0;
      dropOverflow <= 1'b0;
      collectPulse <= 1'b0;
      collectType  <= 2'd0;
    end else begin
      lfsr_r       <= {1'b0, lfsr_r[15:1]} ^ (lfsr_r[0] ? LFSR_MASK : 16'h0000);
      slotValid    <= valid_n_s;
      slotType     <= type_n_s;
      slotX        <= x_n_s;
      age_r        <= age_n_s;
      dropGrant    <= drop_ok_s;
      dropOverflow <= overflow_s;
      collectPulse <= collect_ok_s;
      if (drop_ok_s) begin
        dropSlot <= free_idx_s;
      end else begin
        dropSlot <= dropSlot;
      end
      if (collect_ok_s) begin
        collectType <= slotType[{collectSlot, 1'b0} +: 2];
      end else begin
        collectType <= collectType;
      end
    end
  end

endmodule

// File: tb/tb_present_slot_scheduler.sv
// Directed bench for present_slot_scheduler: fill/overflow, collect, lifetime
// expiry, simultaneous events, play-mode exit and mid-operation reset.
module tb_present_slot_scheduler;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        secClk = 1'b0;
  logic        playActive = 1'b0;
  logic        dropReq = 1'b0;
  logic        collectValid = 1'b0;
  logic [1:0]  collectSlot = 2'd0;
  logic [3:0]  slotValid;
  logic [7:0]  slotType;
  logic [43:0] slotX;
  logic        dropGrant;
  logic [1:0]  dropSlot;
  logic        dropOverflow;
  logic        collectPulse;
  logic [1:0]  collectType;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_lfsr;
  logic [1:0]  exp_type [4];
  logic [10:0] exp_x [4];

  present_slot_scheduler dut (
    .clk(clk), .resetN(resetN), .secClk(secClk), .playActive(playActive),
    .dropReq(dropReq), .collectValid(collectValid), .collectSlot(collectSlot),
    .slotValid(slotValid), .slotType(slotType), .slotX(slotX),
    .dropGrant(dropGrant), .dropSlot(dropSlot), .dropOverflow(dropOverflow),
    .collectPulse(collectPulse), .collectType(collectType)
  );

  always #5 clk = ~clk;

  // Reference LFSR: 16-bit Galois, mask B400, seeded by reset.
  always @(posedge clk) begin
    if (!resetN) m_lfsr <= 16'hACE1;
    else         m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  function automatic logic [10:0] x_from(input logic [15:0] l);
    int raw;
    raw = int'(l[9:0]);
    if (raw >= 576) raw = raw - 576;
    return 11'(32 + raw);
  endfunction

  task automatic chk(input string tag, input logic [43:0] obs, input logic [43:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 44'(slotValid), 44'd0);
    chk({tag, "_type"}, 44'(slotType), 44'd0);
    chk({tag, "_x"}, slotX, 44'd0);
    chk({tag, "_pulses"}, 44'({dropGrant, dropOverflow, collectPulse}), 44'd0);
    chk({tag, "_held"}, 44'({dropSlot, collectType}), 44'd0);
  endtask

  // One drop request; a grant is expected into 'slot', otherwise an overflow.
  task automatic drop(input logic grant, input logic [1:0] slot, input logic with_sec);
    logic [15:0] l;
    logic [10:0] xv;
    l = m_lfsr;
    dropReq = 1'b1;
    secClk = with_sec;
    tick();
    dropReq = 1'b0;
    secClk = 1'b0;
    chk("dropGrant", 44'(dropGrant), 44'(grant));
    chk("dropOverflow", 44'(dropOverflow), 44'(!grant));
    if (grant) begin
      exp_type[slot] = l[15:14];
      exp_x[slot] = x_from(l);
      xv = slotX[11*slot +: 11];
      chk("dropSlot", 44'(dropSlot), 44'(slot));
      chk("slotType", 44'(slotType[2*slot +: 2]), 44'(exp_type[slot]));
      chk("slotX", 44'(xv), 44'(exp_x[slot]));
      chk("x_range", 44'((xv >= 11'd32) && (xv <= 11'd607)), 44'd1);
    end
  endtask

  task automatic collect(input logic [1:0] slot);
    collectValid = 1'b1;
    collectSlot = slot;
    tick();
    collectValid = 1'b0;
  endtask

  task automatic sec_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      secClk = 1'b1;
      tick();
      secClk = 1'b0;
      chk("still_valid", 44'(slotValid[0]), 44'd1);
    end
  endtask

  initial begin
    // 1. Reset held for two edges.
    tick();
    tick();
    chk_all_zero("reset");

    // 2. Release reset with a drop in the same cycle: LFSR=ACE1 gives
    //    type 10 and X = 32 + 225 = 257.
    resetN = 1'b1;
    playActive = 1'b1;
    drop(1'b1, 2'd0, 1'b0);
    chk("seed_type", 44'(slotType[1:0]), 44'd2);
    chk("seed_x", 44'(slotX[10:0]), 44'd257);
    for (int s = 1; s < 4; s++) begin
      tick();
      tick();
      drop(1'b1, 2'(s), 1'b0);
    end
    chk("full_mask", 44'(slotValid), 44'hF);
    tick();
    tick();
    drop(1'b0, 2'd0, 1'b0);
    chk("ovf_mask", 44'(slotValid), 44'hF);
    for (int s = 0; s < 4; s++) begin
      chk("ovf_type_hold", 44'(slotType[2*s +: 2]), 44'(exp_type[s]));
      chk("ovf_x_hold", 44'(slotX[11*s +: 11]), 44'(exp_x[s]));
    end

    // 3. Collect slot 2, retry on the freed slot, then refill it.
    collect(2'd2);
    chk("col_pulse", 44'(collectPulse), 44'd1);
    chk("col_type", 44'(collectType), 44'(exp_type[2]));
    chk("col_mask", 44'(slotValid), 44'hB);
    collect(2'd2);
    chk("col_freed_nopulse", 44'(collectPulse), 44'd0);
    chk("col_type_hold", 44'(collectType), 44'(exp_type[2]));
    drop(1'b1, 2'd2, 1'b0);

    // 5. Full pool: collect slot 1 and drop together -> overflow + collect.
    collectValid = 1'b1;
    collectSlot = 2'd1;
    dropReq = 1'b1;
    tick();
    collectValid = 1'b0;
    dropReq = 1'b0;
    chk("cd_pulse", 44'(collectPulse), 44'd1);
    chk("cd_type", 44'(collectType), 44'(exp_type[1]));
    chk("cd_ovf", 44'(dropOverflow), 44'd1);
    chk("cd_grant", 44'(dropGrant), 44'd0);
    chk("cd_mask", 44'(slotValid), 44'hD);
    drop(1'b1, 2'd1, 1'b0);
    chk("cd_refill", 44'(slotValid), 44'hF);

    // 6a. Leave play mode with a drop pending: pool cleared, request ignored.
    playActive = 1'b0;
    dropReq = 1'b1;
    tick();
    dropReq = 1'b0;
    chk("exit_mask", 44'(slotValid), 44'd0);
    chk("exit_pulses", 44'({dropGrant, dropOverflow}), 44'd0);
    collect(2'd0);
    chk("exit_nocollect", 44'(collectPulse), 44'd0);

    // 4. Lifetime: 5 seconds survive, the 6th frees without a collect pulse.
    playActive = 1'b1;
    drop(1'b1, 2'd0, 1'b0);
    sec_ticks(5);
    secClk = 1'b1;
    tick();
    secClk = 1'b0;
    chk("expire_mask", 44'(slotValid), 44'd0);
    chk("expire_nopulse", 44'(collectPulse), 44'd0);

    // Drop on a secClk cycle starts at age 0; 6th tick coincides with collect.
    drop(1'b1, 2'd0, 1'b1);
    sec_ticks(5);
    secClk = 1'b1;
    collect(2'd0);
    secClk = 1'b0;
    chk("exp_col_pulse", 44'(collectPulse), 44'd1);
    chk("exp_col_type", 44'(collectType), 44'(exp_type[0]));
    chk("exp_col_mask", 44'(slotValid), 44'd0);

    // 6b. Mid-operation reset with three live slots, then seed re-check.
    drop(1'b1, 2'd0, 1'b0);
    drop(1'b1, 2'd1, 1'b0);
    drop(1'b1, 2'd2, 1'b0);
    chk("pre_reset_mask", 44'(slotValid), 44'h7);
    resetN = 1'b0;
    tick();
    chk_all_zero("midreset");
    resetN = 1'b1;
    drop(1'b1, 2'd0, 1'b0);
    chk("reseed_type", 44'(slotType[1:0]), 44'd2);
    chk("reseed_x", 44'(slotX[10:0]), 44'd257);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/present_slot_scheduler.md
Name: present_slot_scheduler

Overview:
- Allocates falling presents (power-ups) into a fixed pool of 4 on-screen slots.
- On each drop request it picks the lowest free slot and assigns a pseudo-random type and X position.
- Frees a slot when its present is collected or when its lifetime expires.
- Sits between the game state machine (drop requests, collection reporting) and the present drawing/collision objects (per-slot valid/type/X).

Parameters:
LIFETIME_SEC, 6, seconds a present stays alive before auto-free (1..7)
X_MIN, 32, leftmost allowed spawn X (pixels)
X_SPAN, 576, number of allowed X positions; spawn X in [X_MIN, X_MIN+X_SPAN-1]; legal range 512..1024
LFSR_SEED, 16'hACE1, non-zero LFSR reset value

Ports:
clk  in  1  system clock
resetN  in  1  synchronous active-low reset
secClk  in  1  one-cycle pulse, once per second
playActive  in  1  high while game is in play mode
dropReq  in  1  one-cycle drop request pulse
collectValid  in  1  one-cycle pulse: player touched a present
collectSlot  in  2  slot index of the touched present
slotValid  out  4  bit i = slot i holds a live present
slotType  out  8  2 bits per slot, slot i at [2i+1:2i]; 00 life, 01 super rope, 10 super speed, 11 immortal
slotX  out  44  11 bits per slot, slot i at [11i+10:11i]
dropGrant  out  1  one-cycle pulse: a drop was allocated
dropSlot  out  2  slot index granted; valid with dropGrant
dropOverflow  out  1  one-cycle pulse: drop requested with no free slot
collectPulse  out  1  one-cycle pulse: valid collection accepted
collectType  out  2  type of collected present; valid with collectPulse

Behaviour:
- Clocking and reset:
  - All state updates on posedge clk.
  - resetN low at a clock edge: LFSR<=LFSR_SEED.
  - Reset also clears: all slotValid, slotType, slotX, slot ages and all pulse outputs. Every output reads 0 the cycle after reset.
  - Reset mid-operation discards live presents immediately.
- LFSR:
  - 16-bit Galois, taps x^16+x^14+x^13+x^11 (mask 16'hB400).
  - Advances every clock not in reset, regardless of playActive.
- Spawn values, sampled from the current LFSR in the dropReq cycle:
  - type = lfsr[15:14]
  - raw = lfsr[9:0]; off = (raw >= X_SPAN) ? raw - X_SPAN : raw; X = X_MIN + off (11-bit)
- Drop, when dropReq && playActive:
  - Target is the lowest-index slot with slotValid=0, using the pre-edge mask.
  - Next cycle: slot valid=1, type and X loaded, age=0, dropGrant=1, dropSlot=index. Latency 1 clock.
  - If all 4 slots are valid: dropOverflow=1 for one cycle, no state change.
- Collect, when collectValid && playActive && slotValid[collectSlot]:
  - Next cycle: slot freed, collectPulse=1, collectType=that slot's stored type.
  - collectValid on an invalid slot is ignored, with no pulse.
- Lifetime:
  - Each slot has a 3-bit age.
  - On secClk, every valid slot with age==LIFETIME_SEC-1 is freed; other valid slots age+1.
- Simultaneous events in one cycle:
  - Collect and expire on the same slot: collect wins, collectPulse asserted.
  - A slot being freed this cycle is not allocatable this cycle; dropReq sees only the pre-edge free mask, so if all were full, overflow is reported.
  - Drop and collect on different slots are both honoured.
  - secClk ages an existing slot but not a slot being allocated that cycle (new slot age=0).
- playActive low:
  - All slots cleared synchronously on the next edge.
  - dropReq and collectValid are ignored and no pulses are generated.
- Pulse outputs default to 0 every cycle unless set by the rules above. collectType and dropSlot hold their last values otherwise.

Test Plan:
1. Reset and defaults: hold resetN=0 for 2 clocks, release -> all outputs 0; LFSR reads 16'hACE1 on the first cycle after release.
2. Fill and overflow: playActive=1, 5 dropReq pulses 3 clocks apart, no secClk -> dropGrant with dropSlot 0,1,2,3, slotValid=4'b1111; fifth request -> dropOverflow=1, slot state unchanged. Every granted X is within [32,607].
3. Collect: slot 2 valid with type 10, collectValid=1, collectSlot=2 -> next cycle collectPulse=1, collectType=10, slotValid[2]=0. Next dropReq -> dropSlot=2. collectValid on freed slot 2 -> no pulse.
4. Lifetime: single present in slot 0, then 5 secClk pulses -> still valid. 6th secClk -> slotValid=0, no collectPulse. On the 6th tick, apply collectValid=1, collectSlot=0 in the same cycle -> collectPulse=1.
5. Full pool with collect + drop same cycle: slotValid=1111, collectValid slot 1 and dropReq together -> collectPulse=1, dropOverflow=1, slotValid=1101. Next dropReq -> dropSlot=1.
6. Mode exit and mid-op reset: 3 slots live, drop playActive -> slotValid=0 next cycle, dropReq ignored. Separately, resetN=0 with slots live -> all cleared, LFSR=16'hACE1.
